// File: rtl/cpu_2432_mem_arb.sv
// ---------------------------------------------------------------------------
// cpu_2432_mem_arb
//
// Arbiter for a single-port synchronous data RAM (1-cycle read latency),
// shared between the cpu_2432 data port and a host/loader port.
//
// The host takes a RAM cycle by freezing the CPU (o_cpu_clk_en = 0) for one
// clock. The following cycle is the ACK cycle, in which the host sees its
// completion pulse and read data. CPU load data that comes back from the RAM
// while the CPU is frozen (because of a host slot or a system stall) is
// caught in a hold register. The CPU sees that data on its first enabled
// cycle.
//
// Optional feature, selected by the macro MEM_ARB_DEFER_EN:
//   Undefined : strict host priority. A pending request gets the next IDLE
//               cycle.
//   Defined   : the host waits for a cycle in which the CPU makes no RAM
//               access. After HOST_WAIT_MAX IDLE cycles of waiting, the slot
//               is forced.
//
// Handshake (host side): i_host_req rises with i_host_wr/i_host_addr/
// i_host_wdata valid and holds them stable until o_host_ack is seen. The
// o_host_ack pulse lasts one cycle, and o_host_rdata is valid only in that
// cycle. If i_host_req is still high after the ack, it is a new request,
// evaluated in the next IDLE cycle.
//
// Ports:
//   i_clk, i_rst        clock; asynchronous active-high reset
//   i_clk_en            system clock enable for the CPU
//   o_cpu_clk_en        clock enable delivered to the CPU
//   i_cpu_daddr/dout    CPU data address / lane-aligned write data
//   i_cpu_ram_rd/wr     CPU read strobe / byte write enables
//   o_cpu_din           read data to the CPU
//   i_host_req/wr/addr/wdata   host request (wr == 0 means read)
//   o_host_ack/rdata    host completion pulse / read data
//   o_ram_*             RAM port;  i_ram_rdata  RAM read data (next cycle)
//   o_dbg_state         FSM state (0 = IDLE, 1 = ACK)
//   o_dbg_hold_vld      hold register holds CPU load data
// ---------------------------------------------------------------------------
module cpu_2432_mem_arb #(
  parameter int AW            = 24,
  parameter int DW            = 32,
  parameter int HOST_WAIT_MAX = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clk_en,
  output logic          o_cpu_clk_en,
  input  logic [AW-1:0] i_cpu_daddr,
  input  logic [DW-1:0] i_cpu_dout,
  input  logic          i_cpu_ram_rd,
  input  logic [3:0]    i_cpu_ram_wr,
  output logic [DW-1:0] o_cpu_din,
  input  logic          i_host_req,
  input  logic [3:0]    i_host_wr,
  input  logic [AW-1:0] i_host_addr,
  input  logic [DW-1:0] i_host_wdata,
  output logic          o_host_ack,
  output logic [DW-1:0] o_host_rdata,
  output logic [AW-1:0] o_ram_addr,
  output logic [DW-1:0] o_ram_wdata,
  output logic          o_ram_rd,
  output logic [3:0]    o_ram_wr,
  input  logic [DW-1:0] i_ram_rdata,
  output logic          o_dbg_state,
  output logic          o_dbg_hold_vld
);

  // The wait counter is 8 bits wide, so the parameter must fit in it.
  if (HOST_WAIT_MAX < 1 || HOST_WAIT_MAX > 255) begin : g_bad_wait_max
    $error("cpu_2432_mem_arb: HOST_WAIT_MAX must be in 1..255");
  end

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_grant_ok;
  logic          w_host_slot;
  logic          w_cpu_clk_en;
  logic          r_host_is_rd;
  logic          r_rd_pend;
  logic          r_hold_vld;
  logic [DW-1:0] r_hold;

  // -------------------------------------------------------------------------
  // Grant qualification
  // -------------------------------------------------------------------------
`ifdef MEM_ARB_DEFER_EN
  localparam logic [7:0] WAIT_LAST = 8'(HOST_WAIT_MAX - 1);

  logic [7:0] r_wait;
  logic       w_cpu_idle;

  assign w_cpu_idle = ~i_cpu_ram_rd & (i_cpu_ram_wr == 4'b0000);
  // A CPU-idle cycle is free to take. When the wait budget runs out, the
  // slot is taken even if the CPU is busy.
  assign w_grant_ok = w_cpu_idle | (r_wait == WAIT_LAST);

  // Counts the IDLE cycles a pending request has been passed over. The
  // count is held through ACK, and it clears when the request goes away or
  // is granted.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wait <= 8'd0;
    end else if (w_host_slot || !i_host_req) begin
      r_wait <= 8'd0;
    end else if (r_state == S_IDLE) begin
      r_wait <= r_wait + 8'd1;
    end
  end
`else
  assign w_grant_ok = 1'b1;
`endif

  // A slot is never granted while reset is asserted. During reset the RAM
  // strobes and the CPU enable simply follow the CPU side.
  assign w_host_slot = (r_state == S_IDLE) & i_host_req & w_grant_ok & ~i_rst;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state. ACK always returns to IDLE, so the host gets at most
  // one access every two cycles.
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_host_slot) w_state_nxt = S_ACK;
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    w_cpu_clk_en = i_clk_en;
    o_ram_addr   = i_cpu_daddr;
    o_ram_wdata  = i_cpu_dout;
    o_ram_rd     = 1'b0;
    o_ram_wr     = 4'b0000;
    o_host_ack   = 1'b0;
    o_host_rdata = '0;

    if (w_host_slot) begin
      w_cpu_clk_en = 1'b0;
      o_ram_addr   = i_host_addr;
      o_ram_wdata  = i_host_wdata;
      o_ram_rd     = (i_host_wr == 4'b0000);
      o_ram_wr     = i_host_wr;
    end else begin
      // A frozen CPU must not touch the RAM. Its strobes may still be
      // asserted from the instruction that is being held.
      o_ram_rd = i_cpu_ram_rd & w_cpu_clk_en;
      o_ram_wr = i_cpu_ram_wr & {4{w_cpu_clk_en}};
    end

    if (r_state == S_ACK) begin
      o_host_ack = 1'b1;
      if (r_host_is_rd) o_host_rdata = i_ram_rdata;
    end
  end

  assign o_cpu_clk_en = w_cpu_clk_en;

  // Records whether the granted host access was a read, so that the ACK
  // cycle returns data only for reads.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_host_is_rd <= 1'b0;
    end else if (w_host_slot) begin
      r_host_is_rd <= (i_host_wr == 4'b0000);
    end
  end

  // -------------------------------------------------------------------------
  // CPU load protection
  //
  // r_rd_pend marks a cycle in which RAM data for the CPU is arriving. If
  // the CPU is frozen in that cycle, it will not latch the data, and the
  // RAM output may be overwritten by a host read. The data is therefore
  // parked in r_hold. The capture happens only while r_hold_vld is clear,
  // so back-to-back frozen cycles keep the first value. The hold is
  // released after the first enabled cycle, which is the cycle in which the
  // CPU consumes it.
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_pend  <= 1'b0;
      r_hold_vld <= 1'b0;
      r_hold     <= '0;
    end else begin
      r_rd_pend <= w_cpu_clk_en & i_cpu_ram_rd;
      if (w_cpu_clk_en) begin
        r_hold_vld <= 1'b0;
      end else if (r_rd_pend && !r_hold_vld) begin
        r_hold     <= i_ram_rdata;
        r_hold_vld <= 1'b1;
      end
    end
  end

  assign o_cpu_din      = r_hold_vld ? r_hold : i_ram_rdata;
  assign o_dbg_state    = (r_state == S_ACK);
  assign o_dbg_hold_vld = r_hold_vld;

endmodule
